// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
// hazard_ctrl_unit : D/X hazard controller (load-use bubbles, multi-cycle
//                    hold, branch flush) with saturating stall/flush counters
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_D,
  input  logic [31:0]      instr_X,
  input  logic             RegWEn_X,
  input  logic             mc_req_X,
  input  logic             mc_done,
  input  logic             branch_taken_X,
  output logic             PCWrite,
  output logic             IF_ID_write,
  output logic             Control_set_zero,
  output logic             stall_X,
  output logic             flush_D,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  localparam logic [2:0]       BCNT_INIT = 3'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    MCWAIT = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] bcnt, bcnt_nxt;

  logic [4:0] rd_x, rs1_d, rs2_d;
  logic [6:0] op_x, op_d;
  logic       uses_rs1, uses_rs2, load_use;
  logic       unused_bits;

  assign rd_x  = instr_X[11:7];
  assign op_x  = instr_X[6:0];
  assign rs1_d = instr_D[19:15];
  assign rs2_d = instr_D[24:20];
  assign op_d  = instr_D[6:0];

  // Fields not involved in hazard detection.
  assign unused_bits = ^{instr_D[31:25], instr_D[14:7], instr_X[31:12]};

  assign uses_rs1 = !((op_d == OP_LUI) || (op_d == OP_AUIPC) || (op_d == OP_JAL));
  assign uses_rs2 = (op_d == OP_REG) || (op_d == OP_STORE) || (op_d == OP_BRANCH);

  assign load_use = (op_x == OP_LOAD) && RegWEn_X && (rd_x != 5'd0) &&
                    ((uses_rs1 && (rs1_d == rd_x)) || (uses_rs2 && (rs2_d == rd_x)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      bcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Mealy outputs: hazards stall in the same cycle they are seen.
  always_comb begin
    state_nxt        = state;
    bcnt_nxt         = bcnt;
    PCWrite          = 1'b1;
    IF_ID_write      = 1'b1;
    Control_set_zero = 1'b0;
    stall_X          = 1'b0;
    flush_D          = 1'b0;

    if (!rst) begin
      case (state)
        RUN: begin
          if (branch_taken_X) begin
            flush_D          = 1'b1;
            Control_set_zero = 1'b1;
          end else if (mc_req_X && !mc_done) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            stall_X     = 1'b1;
            state_nxt   = MCWAIT;
          end else if (load_use) begin
            PCWrite          = 1'b0;
            IF_ID_write      = 1'b0;
            Control_set_zero = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              bcnt_nxt  = BCNT_INIT;
              state_nxt = LSTALL;
            end
          end
        end

        // X already holds a bubble here, so load_use is deliberately ignored.
        LSTALL: begin
          PCWrite          = 1'b0;
          IF_ID_write      = 1'b0;
          Control_set_zero = 1'b1;
          bcnt_nxt         = bcnt - 3'd1;
          if (bcnt <= 3'd1) begin
            state_nxt = RUN;
          end
        end

        MCWAIT: begin
          if (!mc_done) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            stall_X     = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end

        default: begin
          state_nxt = RUN;
          bcnt_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PCWrite && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_D && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
// ============================================================================
// tb_hazard_ctrl_unit : three parameterisations driven in lock-step and
//                       compared against a remaining-bubble/busy-flag model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_D, instr_X;
  logic        RegWEn_X, mc_req_X, mc_done, branch_taken_X;

  always #5 clk = ~clk;

  // Per-instance observed control bundle: {PCWrite, IF_ID_write, Control_set_zero, stall_X, flush_D}
  logic [4:0]  ctl [3];
  logic [15:0] sc  [3];
  logic [15:0] fc  [3];
  logic        pw0, iw0, cz0, sx0, fd0;
  logic        pw1, iw1, cz1, sx1, fd1;
  logic        pw2, iw2, cz2, sx2, fd2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  assign ctl[0] = {pw0, iw0, cz0, sx0, fd0};
  assign ctl[1] = {pw1, iw1, cz1, sx1, fd1};
  assign ctl[2] = {pw2, iw2, cz2, sx2, fd2};
  assign sc[0] = sc0;
  assign fc[0] = fc0;
  assign sc[1] = sc1;
  assign fc[1] = fc1;
  assign sc[2] = {14'd0, sc2};
  assign fc[2] = {14'd0, fc2};

  hazard_ctrl_unit #(.LOAD_USE_STALLS(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .instr_D(instr_D), .instr_X(instr_X), .RegWEn_X(RegWEn_X),
    .mc_req_X(mc_req_X), .mc_done(mc_done), .branch_taken_X(branch_taken_X),
    .PCWrite(pw0), .IF_ID_write(iw0), .Control_set_zero(cz0), .stall_X(sx0),
    .flush_D(fd0), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_ctrl_unit #(.LOAD_USE_STALLS(3), .CNT_W(16)) dut_l3 (
    .clk(clk), .rst(rst), .instr_D(instr_D), .instr_X(instr_X), .RegWEn_X(RegWEn_X),
    .mc_req_X(mc_req_X), .mc_done(mc_done), .branch_taken_X(branch_taken_X),
    .PCWrite(pw1), .IF_ID_write(iw1), .Control_set_zero(cz1), .stall_X(sx1),
    .flush_D(fd1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl_unit #(.LOAD_USE_STALLS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .instr_D(instr_D), .instr_X(instr_X), .RegWEn_X(RegWEn_X),
    .mc_req_X(mc_req_X), .mc_done(mc_done), .branch_taken_X(branch_taken_X),
    .PCWrite(pw2), .IF_ID_write(iw2), .Control_set_zero(cz2), .stall_X(sx2),
    .flush_D(fd2), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Model: bubbles still owed after the current cycle, multi-cycle busy flag, event counts.
  int LUS [3] = '{1, 3, 2};
  int CMAX[3] = '{65535, 65535, 3};
  int rem [3] = '{0, 0, 0};
  bit mcw [3] = '{0, 0, 0};
  int scnt[3] = '{0, 0, 0};
  int fcnt[3] = '{0, 0, 0};

  logic [6:0] OPS [9] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67};

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  function automatic bit is_load_use(input logic [31:0] ix, input logic [31:0] id, input bit rw);
    bit u1, u2;
    u1 = !(id[6:0] inside {7'h37, 7'h17, 7'h6F});
    u2 = id[6:0] inside {7'h33, 7'h23, 7'h63};
    return (ix[6:0] == 7'h03) && rw && (ix[11:7] != 5'd0) &&
           ((u1 && id[19:15] == ix[11:7]) || (u2 && id[24:20] == ix[11:7]));
  endfunction

  // Called at posedge+1: drive, check outputs mid-cycle, cross the edge, check counters.
  task automatic run_cycle(input bit r, input logic [31:0] ix, input logic [31:0] id,
                           input bit rw, input bit mq, input bit md, input bit bt);
    int nrem[3];
    bit nmc[3];
    logic [4:0] e[3];
    rst = r; instr_X = ix; instr_D = id; RegWEn_X = rw;
    mc_req_X = mq; mc_done = md; branch_taken_X = bt;
    #4;
    for (int i = 0; i < 3; i++) begin
      e[i] = 5'b11000; nrem[i] = rem[i]; nmc[i] = mcw[i];
      if (!r) begin
        if (rem[i] > 0) begin
          e[i] = 5'b00100; nrem[i] = rem[i] - 1;
        end else if (mcw[i]) begin
          if (!md) e[i] = 5'b00010;
          else     nmc[i] = 1'b0;
        end else if (bt) begin
          e[i] = 5'b11101;
        end else if (mq && !md) begin
          e[i] = 5'b00010; nmc[i] = 1'b1;
        end else if (is_load_use(ix, id, rw)) begin
          e[i] = 5'b00100; nrem[i] = LUS[i] - 1;
        end
      end
      check_eq($sformatf("ctl[%0d]", i), {27'd0, ctl[i]}, {27'd0, e[i]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        rem[i] = 0; mcw[i] = 1'b0; scnt[i] = 0; fcnt[i] = 0;
      end else begin
        rem[i] = nrem[i]; mcw[i] = nmc[i];
        if (!e[i][4] && scnt[i] < CMAX[i]) scnt[i]++;
        if (e[i][0] && fcnt[i] < CMAX[i]) fcnt[i]++;
      end
      check_eq($sformatf("stall_cnt[%0d]", i), {16'd0, sc[i]}, scnt[i]);
      check_eq($sformatf("flush_cnt[%0d]", i), {16'd0, fc[i]}, fcnt[i]);
    end
  endtask

  task automatic do_reset();
    run_cycle(1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    run_cycle(1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] lw5, lw0, lw7, add625, add600, lui5, sw7;
    logic [31:0] ix, id;
    lw5    = mk(7'h03, 5'd5, 5'd1, 5'd0);
    lw0    = mk(7'h03, 5'd0, 5'd1, 5'd0);
    lw7    = mk(7'h03, 5'd7, 5'd1, 5'd0);
    add625 = mk(7'h33, 5'd6, 5'd2, 5'd5);
    add600 = mk(7'h33, 5'd6, 5'd0, 5'd0);
    lui5   = mk(7'h37, 5'd5, 5'd5, 5'd5);
    sw7    = mk(7'h23, 5'd0, 5'd2, 5'd7);

    rst = 1'b1; instr_X = NOP; instr_D = NOP; RegWEn_X = 1'b0;
    mc_req_X = 1'b0; mc_done = 1'b0; branch_taken_X = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    // Load-use on rs2, single bubble
    run_cycle(1'b0, lw5, add625, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check_eq("lu_rs2_stall_cnt", {16'd0, sc[0]}, 32'd1);

    // No false hazard: lui ignores rs fields, x0 destination never hazards
    do_reset();
    run_cycle(1'b0, lw5, lui5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, lw0, add600, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("no_false_hazard", {16'd0, sc[0]}, 32'd0);

    // Three-bubble load-use into a store
    do_reset();
    repeat (3) run_cycle(1'b0, lw7, sw7, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check_eq("lu3_stall_cnt", {16'd0, sc[1]}, 32'd3);

    // Multi-cycle hold, done in 5th cycle; then req+done together in RUN
    do_reset();
    repeat (4) run_cycle(1'b0, NOP, NOP, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cycle(1'b0, NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0);
    run_cycle(1'b0, NOP, NOP, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("mc_stall_cnt", {16'd0, sc[0]}, 32'd4);

    // Branch beats load-use
    do_reset();
    run_cycle(1'b0, lw5, add625, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("branch_flush_cnt", {16'd0, fc[0]}, 32'd1);
    check_eq("branch_stall_cnt", {16'd0, sc[0]}, 32'd0);

    // Reset in the middle of a three-cycle bubble sequence
    do_reset();
    run_cycle(1'b0, lw7, sw7, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cycle(1'b1, lw7, sw7, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid_lstall_cnt", {16'd0, sc[1]}, 32'd0);
    idle();

    // Saturation on the 2-bit counter
    do_reset();
    repeat (5) run_cycle(1'b0, lw5, add625, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sat_stall_cnt", {16'd0, sc[2]}, 32'd3);

    // Randomized traffic with register indices squeezed to make hazards frequent
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ix = $urandom;
      ix[6:0]  = ($urandom_range(0, 1) == 0) ? 7'h03 : OPS[$urandom_range(0, 8)];
      ix[11:7] = 5'($urandom_range(0, 3));
      id = $urandom;
      id[6:0]   = OPS[$urandom_range(0, 8)];
      id[19:15] = 5'($urandom_range(0, 3));
      id[24:20] = 5'($urandom_range(0, 3));
      run_cycle($urandom_range(0, 49) == 0, ix, id, $urandom_range(0, 3) != 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RV32I core, sitting between decode (D) and execute (X). It detects load-use hazards on both rs1 and rs2, qualified by opcode, and inserts a configurable number of bubbles. It also holds the pipeline for multi-cycle X-stage operations and flushes D on a taken branch or jump. Saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (legal 1..7)
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  reset, synchronous and active-high
- instr_D  in  32  instruction in D stage
- instr_X  in  32  instruction in X stage
- RegWEn_X  in  1  X-stage instruction writes rd
- mc_req_X  in  1  X-stage instruction is a multi-cycle operation (div/rem)
- mc_done  in  1  multi-cycle unit result valid this cycle
- branch_taken_X  in  1  X-stage branch or jump redirects the PC
- PCWrite  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register update enable
- Control_set_zero  out  1  inject a bubble (zero control) into ID/EX
- stall_X  out  1  hold ID/EX and the X-stage operands
- flush_D  out  1  squash IF/ID contents (turn them into a NOP)
- stall_cnt  out  CNT_W  cycles with PCWrite=0
- flush_cnt  out  CNT_W  cycles with flush_D=1

## Operation
- Field decodes:
  - rd_X = instr_X[11:7], rs1_D = instr_D[19:15], rs2_D = instr_D[24:20].
  - op_X = instr_X[6:0], op_D = instr_D[6:0].
- Operand use by D:
  - uses_rs1 = op_D not in {0x37, 0x17, 0x6F}.
  - uses_rs2 = op_D in {0x33, 0x23, 0x63}.
- load_use = (op_X==0x03) & RegWEn_X & (rd_X!=0) & ((uses_rs1 & rs1_D==rd_X) | (uses_rs2 & rs2_D==rd_X)).
- Registered state: FSM {RUN, LSTALL, MCWAIT}, 3-bit bubble counter bcnt, two counters.
- RUN, priority order:
  1. branch_taken_X: flush_D=1, Control_set_zero=1, PC advances. Stay RUN. Any load_use is ignored.
  2. mc_req_X & !mc_done: PCWrite=0, IF_ID_write=0, stall_X=1. Go MCWAIT.
  3. load_use: PCWrite=0, IF_ID_write=0, Control_set_zero=1.
     - LOAD_USE_STALLS==1: stay RUN.
     - Otherwise: bcnt <= LOAD_USE_STALLS-1, go LSTALL.
  4. Otherwise: all enables 1, all stall/flush outputs 0.
- LSTALL:
  - Outputs are the same as RUN item 3. load_use is not re-evaluated, because X now holds a bubble.
  - bcnt decrements each cycle. If bcnt==1, go RUN.
  - Total stall is exactly LOAD_USE_STALLS cycles.
- MCWAIT:
  - mc_done=0: PCWrite=0, IF_ID_write=0, stall_X=1, Control_set_zero=0 (X is held, not bubbled).
  - mc_done=1: outputs as RUN item 4, go RUN.
  - branch_taken_X is ignored in MCWAIT.
- Counters:
  - stall_cnt increments every cycle PCWrite==0.
  - flush_cnt increments every cycle flush_D==1.
  - Both saturate at 2^CNT_W-1.

## Timing
- Control outputs are combinational (Mealy) from state and current inputs. There is zero-cycle latency from hazard to stall.
- Counters are registered and reflect a cycle's event after that cycle's clk edge.
- Reset (rst=1 at an edge):
  - FSM <= RUN, bcnt <= 0, stall_cnt <= 0, flush_cnt <= 0.
  - While rst=1: PCWrite=1, IF_ID_write=1, Control_set_zero=0, stall_X=0, flush_D=0.
- Reset in LSTALL or MCWAIT abandons the stall. Normal RUN behaviour resumes the cycle after rst falls.
- mc_req_X & mc_done in the same RUN cycle: no stall, no state change.
- x0 as rd_X never causes a hazard, even for a load.

## Test plan
- Load-use on rs2, LOAD_USE_STALLS=1:
  - Stimulus: instr_X = lw x5,0(x1) with RegWEn_X=1; instr_D = add x6,x2,x5.
  - Required: PCWrite=0, IF_ID_write=0, Control_set_zero=1 for 1 cycle; stall_cnt=1.
- No false hazard:
  - Stimulus: lw x5 in X; lui x5 in D, then lw x0 in X with add x6,x0,x0 in D.
  - Required: no stall in either case.
- LOAD_USE_STALLS=3, lw x7 in X, sw x7,0(x2) in D:
  - Required: exactly 3 consecutive stall cycles, then RUN; stall_cnt=3.
- Multi-cycle wait:
  - Stimulus: mc_req_X=1 for 5 cycles, mc_done asserted in the 5th cycle.
  - Required: stall_X=1 and PCWrite=0 for 4 cycles; release in the 5th; stall_cnt=4.
- Branch wins over load-use:
  - Stimulus: branch_taken_X=1 with a load_use condition present.
  - Required: flush_D=1, PCWrite=1; flush_cnt increments by 1.
- Reset and saturation:
  - Stimulus: rst pulsed in cycle 2 of a 3-cycle LSTALL.
  - Required: FSM returns to RUN and counters read 0.
  - With CNT_W=2, after 5 stall cycles stall_cnt=3.
